// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART transmitter and receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int   DATA_BITS         = 8;
  localparam logic IDLE_LEVEL        = 1'b1;
  localparam int   CLKS_PER_BIT_DFLT = 868;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses bit_end on the last count.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DFLT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count;

  assign bit_end = (count == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || bit_end) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter with a valid/ready byte input and a registered, idle-high line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DFLT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t                 state;
  logic [DATA_BITS-1:0]   shift;
  logic [2:0]             bit_idx;
  logic                   bit_end;
  logic                   clear;

  // Holding the counter at zero while idle aligns the start bit to the handshake edge.
  assign clear    = (state == IDLE);
  assign tx_ready = (state == IDLE);
  assign tx_busy  = ~tx_ready;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx      <= IDLE_LEVEL;
      shift   <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= IDLE_LEVEL;
          if (tx_valid) begin
            shift   <= tx_data;
            bit_idx <= '0;
            tx      <= ~IDLE_LEVEL;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx      <= shift[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift <= shift >> 1;
            // tx is registered, so the next bit is loaded at the same edge the shift happens.
            if (bit_idx == LAST_BIT) begin
              tx    <= IDLE_LEVEL;
              state <= STOP;
            end else begin
              tx      <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            tx    <= IDLE_LEVEL;
            state <= IDLE;
          end
        end
        default: begin
          tx    <= IDLE_LEVEL;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4; a monitor checks every tx cycle against queued bytes.
module tb_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;

  int passes = 0;
  int checks = 0;
  int frames_done = 0;

  logic [7:0] exp_q[$];

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor: a falling tx from idle starts a frame; every one of its 40 cycles is compared.
  logic [9:0] frame_bits;
  int         mon_pos = 0;
  bit         in_frame = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'(exp_q.size()), 32'd1);
        end else begin
          frame_bits = {1'b1, exp_q.pop_front(), 1'b0};
          in_frame   = 1'b1;
          mon_pos    = 1;
          chk("ready_at_start", 32'(tx_ready), 32'd0);
        end
      end
    end else begin
      chk("frame_bit", 32'(tx), 32'(frame_bits[mon_pos / CPB]));
      mon_pos++;
      if (mon_pos == 10 * CPB) begin
        in_frame = 1'b0;
        frames_done++;
      end
    end
  end

  task automatic wait_ready(input string tag);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (tx_ready !== 1'b1) chk(tag, 32'(tx_ready), 32'd1);
  endtask

  // Drive one handshake at the next edge; inputs change 1 time unit after posedge.
  task automatic send(input logic [7:0] b);
    wait_ready("send_timeout");
    @(posedge clk); #1;
    tx_data  = b;
    tx_valid = 1'b1;
    exp_q.push_back(b);
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int idle_cnt;
    int seg;
    bit prev_busy;

    // Reset with a pending byte on the inputs.
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    repeat (3) begin
      @(negedge clk);
    end
    chk("reset_tx_low_rst", 32'(tx), 32'd1);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    tx_valid = 1'b0;
    @(negedge clk);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_ready", 32'(tx_ready), 32'd1);
    chk("reset_busy", 32'(tx_busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("reset_no_frame", 32'(tx), 32'd1);

    // Single byte; ready must stay low exactly 40 cycles.
    send(8'hA5);
    chk("a5_ready_low", 32'(tx_ready), 32'd0);
    busy_cnt = 0;
    while (tx_ready !== 1'b1 && busy_cnt < 200) begin
      @(negedge clk);
      if (tx_ready !== 1'b1) busy_cnt++;
    end
    chk("a5_busy_cycles", 32'(busy_cnt), 32'(10 * CPB));
    chk("a5_frames", 32'(frames_done), 32'd1);

    // Back-to-back with tx_valid held high.
    repeat (3) @(posedge clk);
    #1;
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    exp_q.push_back(8'h00);
    @(posedge clk); #1;
    tx_data = 8'hFF;
    exp_q.push_back(8'hFF);
    busy_cnt  = 0;
    idle_cnt  = 0;
    seg       = 1;
    prev_busy = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (tx_busy === 1'b1) begin
        if (!prev_busy) begin
          seg++;
          tx_valid = 1'b0;
        end
        busy_cnt++;
      end else begin
        if (seg == 2) break;
        idle_cnt++;
      end
      prev_busy = (tx_busy === 1'b1);
    end
    tx_valid = 1'b0;
    chk("b2b_gap", 32'(idle_cnt), 32'd1);
    chk("b2b_span", 32'(busy_cnt + idle_cnt), 32'(20 * CPB + 1));
    chk("b2b_frames", 32'(frames_done), 32'd3);

    // Busy ignore: valid pulses and data churn mid-frame must not disturb the frame.
    send(8'h3C);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      tx_data  = (k % 2 == 0) ? 8'hC3 : 8'h5A ^ 8'(k);
      tx_valid = (k >= 3 && k <= 6);
    end
    tx_valid = 1'b0;
    wait_ready("ignore_timeout");
    repeat (10 * CPB + 5) @(negedge clk);
    chk("ignore_idle_tx", 32'(tx), 32'd1);
    chk("ignore_frames", 32'(frames_done), 32'd4);
    chk("ignore_queue", 32'(exp_q.size()), 32'd0);

    // Mid-frame reset: abandon 8'h55 at cycle 15, then a clean 8'h81.
    send(8'h55);
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_ready", 32'(tx_ready), 32'd1);
    repeat (10 * CPB) @(negedge clk);
    chk("mid_rst_no_tail", 32'(tx), 32'd1);
    chk("mid_rst_frames", 32'(frames_done), 32'd4);
    send(8'h81);
    wait_ready("final_timeout");
    @(negedge clk);
    chk("final_frames", 32'(frames_done), 32'd5);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
